// File: rtl/xadc_drp_pkg.sv
// rtl/xadc_drp_pkg.sv - shared types and constants for the XADC DRP read arbiter
package xadc_drp_pkg;

   // Read sequencer states: one DRP read in flight at a time.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } drp_state_t;

   // Commonly used XADC DRP register addresses.
   localparam logic [6:0] ADDR_TEMP   = 7'h00;
   localparam logic [6:0] ADDR_VCCINT = 7'h01;
   localparam logic [6:0] ADDR_VAUX5  = 7'h15;

   // XADC conversion results are left-justified: the 12-bit sample is do[15:4].
   function automatic logic [11:0] xadc_sample12(input logic [15:0] drp_word);
      return drp_word[15:4];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of one requester
//
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   PTR_W    highest-priority requester for this pick
//   gnt     out  NUM_REQ  one-hot grant (all zero when no request)
//   any_req out  1        at least one request is pending
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               any_req
);

   logic [PTR_W:0] pos;
   logic           found;

   // Walk from ptr upward with wrap; the first request hit wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pos   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         pos = {1'b0, ptr} + (PTR_W+1)'(off);
         if (pos >= (PTR_W+1)'(NUM_REQ)) begin
            pos = pos - (PTR_W+1)'(NUM_REQ);
         end
         if (!found && req[pos[PTR_W-1:0]]) begin
            gnt[pos[PTR_W-1:0]] = 1'b1;
            found               = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/xadc_drp_arbiter.sv
// rtl/xadc_drp_arbiter.sv - round-robin sharing of the XADC DRP read port
//
// Ports:
//   clk, reset        clock (also XADC dclk_in), async active-high reset
//   req, req_addr     per-requester level request and packed DRP address
//   rsp_valid         one-cycle completion pulse to the served requester
//   rsp_data          read data (0 on timeout), held until the next response
//   rsp_timeout       response was abandoned for lack of drdy
//   drp_den/daddr/dwe DRP control towards the XADC (read only, dwe=0)
//   drp_do, drp_drdy  DRP read data and ready from the XADC
//   eoc_in            XADC end-of-conversion
//   busy              sequencer not idle
//   timeout_count     saturating count of abandoned reads
module xadc_drp_arbiter
   import xadc_drp_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 16,
   parameter int TIMEOUT_CYC = 255,
   parameter int WAIT_EOC    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_timeout,
   output logic                      drp_den,
   output logic [ADDR_W-1:0]         drp_daddr,
   output logic                      drp_dwe,
   input  logic [DATA_W-1:0]         drp_do,
   input  logic                      drp_drdy,
   input  logic                      eoc_in,
   output logic                      busy,
   output logic [7:0]                timeout_count
);

   localparam int         PTR_W    = $clog2(NUM_REQ);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   drp_state_t           state_q, state_d;
   logic [PTR_W-1:0]     idx_q, idx_d;
   logic [PTR_W-1:0]     rr_q, rr_d;
   logic                 eoc_pending_q, eoc_pending_d;
   logic [7:0]           wait_cnt_q, wait_cnt_d;
   logic                 den_q, den_d;
   logic [ADDR_W-1:0]    daddr_q, daddr_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
   logic                 rsp_timeout_q, rsp_timeout_d;
   logic                 busy_q, busy_d;
   logic [7:0]           tmo_cnt_q, tmo_cnt_d;

   logic [NUM_REQ-1:0]   gnt;
   logic                 any_req;
   logic [PTR_W-1:0]     gnt_idx;
   logic [ADDR_W-1:0]    gnt_addr;
   logic                 eoc_ok;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req     (req),
      .ptr     (rr_q),
      .gnt     (gnt),
      .any_req (any_req)
   );

   always_comb begin
      gnt_idx  = '0;
      gnt_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx  = PTR_W'(i);
            gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // A live eoc_in counts as fresh so the grant needs no extra cycle.
   assign eoc_ok = (WAIT_EOC == 0) || eoc_pending_q || eoc_in;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rr_d          = rr_q;
      wait_cnt_d    = wait_cnt_q;
      den_d         = 1'b0;
      daddr_d       = daddr_q;
      rsp_valid_d   = '0;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      tmo_cnt_d     = tmo_cnt_q;

      // Set after clear so an EOC arriving during ISSUE is kept.
      eoc_pending_d = eoc_pending_q;
      if (state_q == ST_ISSUE) begin
         eoc_pending_d = 1'b0;
      end
      if (eoc_in) begin
         eoc_pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (any_req && eoc_ok) begin
               idx_d   = gnt_idx;
               daddr_d = gnt_addr;
               den_d   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (drp_drdy) begin
               rsp_data_d         = drp_do;
               rsp_timeout_d      = 1'b0;
               rsp_valid_d[idx_q] = 1'b1;
               state_d            = ST_RESP;
            end else if (wait_cnt_q == TMO_LAST) begin
               rsp_data_d         = '0;
               rsp_timeout_d      = 1'b1;
               rsp_valid_d[idx_q] = 1'b1;
               if (tmo_cnt_q != 8'hFF) begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
               state_d            = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_RESP: begin
            rr_d    = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         rr_q          <= '0;
         eoc_pending_q <= 1'b0;
         wait_cnt_q    <= '0;
         den_q         <= 1'b0;
         daddr_q       <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rr_q          <= rr_d;
         eoc_pending_q <= eoc_pending_d;
         wait_cnt_q    <= wait_cnt_d;
         den_q         <= den_d;
         daddr_q       <= daddr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign drp_den       = den_q;
   assign drp_daddr     = daddr_q;
   assign drp_dwe       = 1'b0;
   assign busy          = busy_q;
   assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb/tb_xadc_drp_arbiter.sv - self-checking bench for xadc_drp_arbiter
module tb_xadc_drp_arbiter;
   import xadc_drp_pkg::*;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic [3:0]  req_a = '0;
   logic [27:0] req_addr_a;
   logic [3:0]  rsp_valid_a;
   logic [15:0] rsp_data_a;
   logic        rsp_timeout_a, den_a, dwe_a, busy_a;
   logic [6:0]  daddr_a;
   logic [15:0] drp_do_a = '0;
   logic        drdy_a = 1'b0;
   logic [7:0]  tcnt_a;

   logic [3:0]  req_e = '0;
   logic [3:0]  rsp_valid_e;
   logic [15:0] rsp_data_e;
   logic        rsp_timeout_e, den_e, dwe_e, busy_e;
   logic [6:0]  daddr_e;
   logic        eoc_e = 1'b0;
   logic [7:0]  tcnt_e;

   logic [6:0]  exp_addr [4];

   typedef struct {
      int          idx;
      logic [15:0] data;
      logic        to;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int   total = 0, bad = 0, cyc = 0;
   int   model_lat = 0, countdown = 0, last_den = -100, den_count = 0;
   bit   outstanding = 0, force_drdy = 0;
   logic [6:0] den_addr = '0;

   always #5 clk = ~clk;

   xadc_drp_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(16), .TIMEOUT_CYC(TMO), .WAIT_EOC(0)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .req_addr(req_addr_a),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_timeout(rsp_timeout_a),
      .drp_den(den_a), .drp_daddr(daddr_a), .drp_dwe(dwe_a), .drp_do(drp_do_a),
      .drp_drdy(drdy_a), .eoc_in(1'b0), .busy(busy_a), .timeout_count(tcnt_a));

   xadc_drp_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(16), .TIMEOUT_CYC(TMO), .WAIT_EOC(1)) dut_e (
      .clk(clk), .reset(reset), .req(req_e), .req_addr(req_addr_a),
      .rsp_valid(rsp_valid_e), .rsp_data(rsp_data_e), .rsp_timeout(rsp_timeout_e),
      .drp_den(den_e), .drp_daddr(daddr_e), .drp_dwe(dwe_e), .drp_do(16'h1234),
      .drp_drdy(1'b0), .eoc_in(eoc_e), .busy(busy_e), .timeout_count(tcnt_e));

   function automatic logic [15:0] model_data(input logic [6:0] a);
      return (a == 7'h15) ? 16'hABC0 : {4'h5, a, 5'h00};
   endfunction

   task automatic push_exp(input int idx, input logic [15:0] d, input logic to, input int c);
      exp_t e;
      e.idx = idx; e.data = d; e.to = to; e.cyc = c;
      sb.push_back(e);
   endtask

   // One clock: drive the DRP model for this cycle, then observe dut_a.
   task automatic tick();
      exp_t       e;
      logic [3:0] ev;
      @(posedge clk); #1;
      cyc++;
      drdy_a = 1'b0;
      drp_do_a = 16'hDEAD;
      if (countdown > 0) begin
         countdown--;
         if (countdown == 0) begin
            drdy_a = 1'b1;
            drp_do_a = model_data(den_addr);
         end
      end
      if (force_drdy) drdy_a = 1'b1;
      if (den_a) begin
         den_count++;
         total++;
         if (outstanding) begin bad++; $display("FAIL den_overlap cyc=%0d outstanding=1 required=0", cyc); end
         total++;
         if (cyc - last_den < 4) begin bad++; $display("FAIL den_spacing gap=%0d required>=4", cyc - last_den); end
         outstanding = 1; last_den = cyc; den_addr = daddr_a;
         if (model_lat > 0) countdown = model_lat;
      end
      if (rsp_valid_a != 4'b0) begin
         outstanding = 0;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL unexpected_rsp cyc=%0d valid=%b required=0000", cyc, rsp_valid_a);
         end else begin
            e = sb.pop_front();
            ev = 4'b0001 << e.idx;
            if (rsp_valid_a !== ev) begin bad++; $display("FAIL rsp_valid got=%b required=%b", rsp_valid_a, ev); end
            total++;
            if (rsp_data_a !== e.data) begin bad++; $display("FAIL rsp_data got=%h required=%h", rsp_data_a, e.data); end
            total++;
            if (rsp_timeout_a !== e.to) begin bad++; $display("FAIL rsp_timeout got=%b required=%b", rsp_timeout_a, e.to); end
            if (e.cyc >= 0) begin
               total++;
               if (cyc != e.cyc) begin bad++; $display("FAIL rsp_latency cyc=%0d required=%0d", cyc, e.cyc); end
            end
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() > 0; i++) tick();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL drain_timeout pending=%0d required=0", sb.size()); end
      sb.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      sb.delete(); outstanding = 0; countdown = 0; last_den = -100;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tick(); tick();
      total++;
      if ({den_a, daddr_a, rsp_valid_a, rsp_data_a, rsp_timeout_a, busy_a, tcnt_a, dwe_a} !== '0) begin
         bad++; $display("FAIL reset_outputs den=%b addr=%h v=%b d=%h to=%b busy=%b tc=%0d required all 0",
                         den_a, daddr_a, rsp_valid_a, rsp_data_a, rsp_timeout_a, busy_a, tcnt_a);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      int n;
      model_lat = 1;
      tick();
      n = cyc; req_a = 4'b0001;
      push_exp(0, 16'hABC0, 1'b0, n + 3);
      tick();
      req_a = 4'b0000;
      total++;
      if (den_a !== 1'b1) begin bad++; $display("FAIL single_den got=%b required=1", den_a); end
      total++;
      if (daddr_a !== ADDR_VAUX5) begin bad++; $display("FAIL single_daddr got=%h required=15", daddr_a); end
      wait_drain(20);
      tick(); tick();
      total++;
      if (xadc_sample12(rsp_data_a) !== 12'hABC) begin
         bad++; $display("FAIL data_hold got=%h required=abc", xadc_sample12(rsp_data_a));
      end
   endtask

   task automatic test_back_to_back();
      int seq [5];
      seq = '{0, 1, 2, 3, 0};
      apply_reset();
      model_lat = 2; den_count = 0;
      foreach (seq[i]) push_exp(seq[i], model_data(exp_addr[seq[i]]), 1'b0, -1);
      req_a = 4'b1111;
      for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
      req_a = 4'b0000;
      wait_drain(1);
      for (int i = 0; i < 10; i++) tick();
      total++;
      if (den_count != 5) begin bad++; $display("FAIL b2b_den_count got=%0d required=5", den_count); end
   endtask

   task automatic test_timeout();
      int n;
      model_lat = 0;
      tick();
      n = cyc; req_a = 4'b0001;
      push_exp(0, 16'h0000, 1'b1, n + 2 + TMO);
      tick();
      req_a = 4'b0000;
      wait_drain(40);
      total++;
      if (tcnt_a !== 8'd1) begin bad++; $display("FAIL timeout_count got=%0d required=1", tcnt_a); end
      model_lat = 1;
      tick();
      n = cyc; req_a = 4'b0100;
      push_exp(2, model_data(exp_addr[2]), 1'b0, n + 3);
      tick();
      req_a = 4'b0000;
      wait_drain(20);
      total++;
      if (tcnt_a !== 8'd1) begin bad++; $display("FAIL timeout_count_after got=%0d required=1", tcnt_a); end
   endtask

   task automatic test_reset_in_wait();
      int n;
      model_lat = 0;
      tick();
      req_a = 4'b0001;
      tick();
      req_a = 4'b0000;
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      total++;
      if ({den_a, daddr_a, rsp_valid_a, rsp_data_a, rsp_timeout_a, busy_a, tcnt_a} !== '0) begin
         bad++; $display("FAIL reset_in_wait den=%b addr=%h v=%b d=%h to=%b busy=%b tc=%0d required all 0",
                         den_a, daddr_a, rsp_valid_a, rsp_data_a, rsp_timeout_a, busy_a, tcnt_a);
      end
      outstanding = 0; countdown = 0; last_den = -100;
      tick();
      reset = 1'b0;
      force_drdy = 1;
      tick();
      force_drdy = 0;
      tick(); tick();
      model_lat = 1;
      n = cyc; req_a = 4'b1010;
      push_exp(1, model_data(exp_addr[1]), 1'b0, n + 3);
      tick();
      req_a = 4'b0000;
      wait_drain(20);
   endtask

   task automatic test_drdy_outside_wait();
      int          n;
      logic [15:0] held;
      held = model_data(exp_addr[1]);
      force_drdy = 1;
      tick();
      force_drdy = 0;
      tick(); tick();
      total++;
      if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_drdy_busy got=%b required=0", busy_a); end
      total++;
      if (rsp_data_a !== held) begin bad++; $display("FAIL idle_drdy_data got=%h required=%h", rsp_data_a, held); end
      model_lat = 0;
      n = cyc; req_a = 4'b0001;
      push_exp(0, 16'h0000, 1'b1, n + 2 + TMO);
      force_drdy = 1;
      tick();
      force_drdy = 0; req_a = 4'b0000;
      tick(); tick();
      total++;
      if (busy_a !== 1'b1) begin bad++; $display("FAIL issue_drdy_busy got=%b required=1", busy_a); end
      total++;
      if (rsp_data_a !== held) begin bad++; $display("FAIL issue_drdy_data got=%h required=%h", rsp_data_a, held); end
      wait_drain(40);
      total++;
      if (tcnt_a !== 8'd1) begin bad++; $display("FAIL issue_drdy_tcnt got=%0d required=1", tcnt_a); end
   endtask

   task automatic test_eoc_gating();
      int dens = 0;
      bit seen = 0;
      req_e = 4'b0100;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (den_e) dens++;
      end
      total++;
      if (dens != 0 || busy_e !== 1'b0) begin bad++; $display("FAIL eoc_hold dens=%0d busy=%b required 0/0", dens, busy_e); end
      eoc_e = 1'b1;
      tick();
      eoc_e = 1'b0; req_e = 4'b0000;
      total++;
      if (den_e !== 1'b1) begin bad++; $display("FAIL eoc_den got=%b required=1", den_e); end
      total++;
      if (daddr_e !== exp_addr[2]) begin bad++; $display("FAIL eoc_daddr got=%h required=%h", daddr_e, exp_addr[2]); end
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (rsp_valid_e != 4'b0) begin
            seen = 1;
            total++;
            if (rsp_valid_e !== 4'b0100 || rsp_timeout_e !== 1'b1) begin
               bad++; $display("FAIL eoc_rsp valid=%b to=%b required 0100/1", rsp_valid_e, rsp_timeout_e);
            end
         end
      end
      total++;
      if (!seen) begin bad++; $display("FAIL eoc_rsp_missing got=0 required=1"); end
   endtask

   initial begin
      exp_addr = '{ADDR_VAUX5, ADDR_VCCINT, 7'h10, ADDR_TEMP};
      req_addr_a = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
      test_reset();
      test_single_read();
      test_back_to_back();
      test_timeout();
      test_reset_in_wait();
      test_drdy_outside_wait();
      test_eoc_gating();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
